// File: rtl/step_seq_mixer_if.sv
// Bus between the keypad/mode controller, the step sequencer core and the
// sample player / PWM side. Controller is the master; the core is the slave.
interface step_seq_mixer_if #(
  parameter int N_CH      = 4,
  parameter int N_STEPS   = 8,
  parameter int PW        = 20,
  parameter int SW        = 8,
  parameter int OUT_SHIFT = 2
);
  localparam int IW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  logic [1:0]              mode;
  logic                    cur_left;
  logic                    cur_right;
  logic [N_CH-1:0]         tgl;
  logic [N_CH-1:0]         raw_trig;
  logic [N_CH-1:0]         mute;
  logic [PW-1:0]           step_period;
  logic [PW-1:0]           gate_len;
  logic [N_CH*SW-1:0]      smpl_in;
  logic [N_STEPS-1:0]      step_onehot;
  logic [IW-1:0]           step_idx;
  logic [N_STEPS*N_CH-1:0] pattern;
  logic [N_CH-1:0]         gate;
  logic                    step_tick;
  logic [SW-OUT_SHIFT-1:0] mix_out;

  modport master (
    output mode, cur_left, cur_right, tgl, raw_trig, mute,
           step_period, gate_len, smpl_in,
    input  step_onehot, step_idx, pattern, gate, step_tick, mix_out
  );

  modport slave (
    input  mode, cur_left, cur_right, tgl, raw_trig, mute,
           step_period, gate_len, smpl_in,
    output step_onehot, step_idx, pattern, gate, step_tick, mix_out
  );
endinterface

// File: rtl/step_seq_mixer.sv
// Drum step sequencer core: cursor-edited trigger pattern, timed playback
// with programmable step period and gate length, and an N-channel mixer that
// saturates the full sum and emits offset-binary samples for the PWM stage.
module step_seq_mixer #(
  parameter int N_CH      = 4,
  parameter int N_STEPS   = 8,
  parameter int PW        = 20,
  parameter int SW        = 8,
  parameter int OUT_SHIFT = 2
) (
  input logic             clk,
  input logic             rst,
  step_seq_mixer_if.slave bus
);
  localparam int IW    = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int MW    = SW - OUT_SHIFT;
  localparam int ACC_W = SW + $clog2(N_CH);

  localparam logic [IW-1:0]           LAST_STEP = IW'(N_STEPS - 1);
  localparam logic [MW-1:0]           MIX_ZERO  = MW'(1) << (MW - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI    = ACC_W'((1 << (SW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO    = ACC_W'(-(1 << (SW - 1)));

  typedef enum logic [1:0] {
    MODE_EDIT  = 2'b00,
    MODE_PLAY  = 2'b01,
    MODE_RAW   = 2'b10,
    MODE_PAUSE = 2'b11
  } mode_t;

  mode_t mode;
  assign mode = mode_t'(bus.mode);

  // Sequencer state
  logic [IW-1:0]           cursor, cursor_d;
  logic [IW-1:0]           play_step, step_d;
  logic [PW-1:0]           cnt, cnt_d;
  logic [N_STEPS*N_CH-1:0] pattern_q, pattern_d;
  logic [PW-1:0]           cnt_last;
  logic [N_CH-1:0]         cur_row, play_row;

  // Registered outputs
  logic [N_CH-1:0]         gate_p0, gate_p1;
  logic                    tick_p0, tick_p1;
  logic signed [ACC_W-1:0] mix_sum_p0;
  logic signed [SW-1:0]    smp_p0;
  logic signed [SW-1:0]    mix_sat_p0;
  logic [MW-1:0]           mix_p0, mix_p1;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == LAST_STEP) ? '0 : v + IW'(1);
  endfunction

  function automatic logic [IW-1:0] wrap_dec(input logic [IW-1:0] v);
    return (v == '0) ? LAST_STEP : v - IW'(1);
  endfunction

  // Only the final sum is clamped; channels are never saturated pairwise.
  function automatic logic signed [SW-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return SAT_HI[SW-1:0];
    else if (v < SAT_LO) return SAT_LO[SW-1:0];
    else                 return v[SW-1:0];
  endfunction

  // Next-state for cursor, pattern, step counter, gate and step tick
  always_comb begin
    cursor_d  = cursor;
    step_d    = play_step;
    cnt_d     = cnt;
    pattern_d = pattern_q;
    gate_p0   = '0;
    tick_p0   = 1'b0;
    cur_row   = pattern_q[int'(cursor)*N_CH +: N_CH];
    play_row  = pattern_q[int'(play_step)*N_CH +: N_CH];
    // A step_period of 0 behaves as 1; a counter already past the new
    // compare value wraps on the next cycle.
    cnt_last  = (bus.step_period == '0) ? '0 : bus.step_period - PW'(1);
    unique case (mode)
      MODE_EDIT: begin
        // Toggle lands on the cursor as it was before any move this cycle.
        pattern_d[int'(cursor)*N_CH +: N_CH] = cur_row ^ bus.tgl;
        if (bus.cur_left && !bus.cur_right)
          cursor_d = wrap_inc(cursor);
        else if (bus.cur_right && !bus.cur_left)
          cursor_d = wrap_dec(cursor);
        cnt_d  = '0;
        step_d = '0;
      end
      MODE_PLAY: begin
        gate_p0 = (play_row & {N_CH{cnt < bus.gate_len}}) | bus.raw_trig;
        if (cnt >= cnt_last) begin
          cnt_d   = '0;
          step_d  = wrap_inc(play_step);
          tick_p0 = 1'b1;
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      MODE_RAW: begin
        gate_p0 = bus.raw_trig;
        cnt_d   = '0;
        step_d  = '0;
      end
      default: begin
        // PAUSE: counter and step frozen so PLAY can resume in place.
        gate_p0 = bus.raw_trig;
      end
    endcase
  end

  // Sequencer registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor    <= '0;
      play_step <= '0;
      cnt       <= '0;
      pattern_q <= '0;
      gate_p1   <= '0;
      tick_p1   <= 1'b0;
    end else begin
      cursor    <= cursor_d;
      play_step <= step_d;
      cnt       <= cnt_d;
      pattern_q <= pattern_d;
      gate_p1   <= gate_p0;
      tick_p1   <= tick_p0;
    end
  end

  // Mixer sum of unmuted sign-extended channels, clamp, then offset binary
  always_comb begin
    mix_sum_p0 = '0;
    smp_p0     = '0;
    for (int c = 0; c < N_CH; c++) begin
      smp_p0 = bus.smpl_in[c*SW +: SW];
      if (!bus.mute[c])
        mix_sum_p0 = mix_sum_p0 + ACC_W'(smp_p0);
    end
    mix_sat_p0 = sat_clamp(mix_sum_p0);
    mix_p0     = MW'({~mix_sat_p0[SW-1], mix_sat_p0[SW-2:0]} >> OUT_SHIFT);
  end

  // ---- stage p0 -> p1: mixer output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mix_p1 <= MIX_ZERO;
    else      mix_p1 <= mix_p0;
  end

  assign bus.step_idx    = (mode == MODE_EDIT) ? cursor : play_step;
  assign bus.step_onehot = N_STEPS'(1) << bus.step_idx;
  assign bus.pattern     = pattern_q;
  assign bus.gate        = gate_p1;
  assign bus.step_tick   = tick_p1;
  assign bus.mix_out     = mix_p1;
endmodule

// File: tb/tb_step_seq_mixer.sv
// Bench for step_seq_mixer: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural model of the sequencer.
module tb_step_seq_mixer;
  localparam int N_CH      = 4;
  localparam int N_STEPS   = 8;
  localparam int PW        = 20;
  localparam int SW        = 8;
  localparam int OUT_SHIFT = 2;
  localparam int MW        = SW - OUT_SHIFT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_seq_mixer_if #(.N_CH(N_CH), .N_STEPS(N_STEPS), .PW(PW), .SW(SW),
                      .OUT_SHIFT(OUT_SHIFT)) bus ();

  step_seq_mixer #(.N_CH(N_CH), .N_STEPS(N_STEPS), .PW(PW), .SW(SW),
                   .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N_CH-1:0] pat [N_STEPS];
  int              cursor, step, cnt;
  logic [N_CH-1:0] exp_gate;
  logic            exp_tick;
  logic [MW-1:0]   exp_mix;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < N_STEPS; s++) pat[s] = '0;
    cursor   = 0;
    step     = 0;
    cnt      = 0;
    exp_gate = '0;
    exp_tick = 1'b0;
    exp_mix  = MW'(1 << (SW - 1 - OUT_SHIFT));
  endtask

  // Applies the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    int sum, p;
    sum = 0;
    for (int c = 0; c < N_CH; c++)
      if (!bus.mute[c]) sum += int'($signed(bus.smpl_in[c*SW +: SW]));
    if (sum > (1 << (SW - 1)) - 1) sum = (1 << (SW - 1)) - 1;
    if (sum < -(1 << (SW - 1)))    sum = -(1 << (SW - 1));
    exp_mix  = MW'((sum + (1 << (SW - 1))) >> OUT_SHIFT);
    exp_tick = 1'b0;
    p = (bus.step_period == '0) ? 1 : int'(bus.step_period);
    case (bus.mode)
      2'b00: begin
        exp_gate    = '0;
        pat[cursor] = pat[cursor] ^ bus.tgl;
        if (bus.cur_left && !bus.cur_right)      cursor = (cursor + 1) % N_STEPS;
        else if (bus.cur_right && !bus.cur_left) cursor = (cursor + N_STEPS - 1) % N_STEPS;
        cnt  = 0;
        step = 0;
      end
      2'b01: begin
        exp_gate = ((cnt < int'(bus.gate_len)) ? pat[step] : '0) | bus.raw_trig;
        if (cnt >= p - 1) begin
          cnt      = 0;
          step     = (step + 1) % N_STEPS;
          exp_tick = 1'b1;
        end else begin
          cnt++;
        end
      end
      2'b10: begin
        exp_gate = bus.raw_trig;
        cnt      = 0;
        step     = 0;
      end
      default: exp_gate = bus.raw_trig;
    endcase
  endtask

  task automatic check_all();
    logic [N_STEPS*N_CH-1:0] pflat;
    int idx;
    for (int s = 0; s < N_STEPS; s++) pflat[s*N_CH +: N_CH] = pat[s];
    idx = (bus.mode == 2'b00) ? cursor : step;
    check("gate",        bus.gate,        exp_gate);
    check("step_tick",   bus.step_tick,   exp_tick);
    check("mix_out",     bus.mix_out,     exp_mix);
    check("step_idx",    bus.step_idx,    idx);
    check("step_onehot", bus.step_onehot, 1 << idx);
    check("pattern",     bus.pattern,     pflat);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_left();
    bus.cur_left = 1'b1; cycle(); bus.cur_left = 1'b0;
  endtask

  task automatic pulse_right();
    bus.cur_right = 1'b1; cycle(); bus.cur_right = 1'b0;
  endtask

  task automatic pulse_tgl(input logic [N_CH-1:0] t);
    bus.tgl = t; cycle(); bus.tgl = '0;
  endtask

  task automatic set_smpl(input int s0, input int s1, input int s2, input int s3);
    bus.smpl_in = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
  endtask

  initial begin
    bus.mode        = 2'b00;
    bus.cur_left    = 1'b0;
    bus.cur_right   = 1'b0;
    bus.tgl         = '0;
    bus.raw_trig    = '0;
    bus.mute        = '0;
    bus.step_period = '0;
    bus.gate_len    = '0;
    bus.smpl_in     = '0;
    model_reset();

    // Reset state
    #1 rst = 1'b0;
    #11;
    check_all();
    check("reset_mix", bus.mix_out, 32);
    check("reset_onehot", bus.step_onehot, 8'b0000_0001);
    @(negedge clk);
    rst = 1'b1;

    // Cursor movement with wrap
    for (int i = 0; i < 3; i++) pulse_left();
    check("cursor_left3", bus.step_idx, 3);
    check("cursor_onehot3", bus.step_onehot, 8'b0000_1000);
    for (int i = 0; i < 4; i++) pulse_right();
    check("cursor_wrap7", bus.step_idx, 7);

    // Toggling at the cursor; move + toggle in one cycle
    for (int i = 0; i < 3; i++) pulse_left();
    check("cursor_at2", bus.step_idx, 2);
    pulse_tgl(4'b1001);
    check("pat2_set", bus.pattern[8 +: 4], 4'b1001);
    pulse_tgl(4'b1001);
    check("pat2_clr", bus.pattern[8 +: 4], 4'b0000);
    bus.cur_left = 1'b1; bus.cur_right = 1'b1; bus.tgl = 4'b0001;
    cycle();
    bus.cur_left = 1'b0; bus.cur_right = 1'b0; bus.tgl = '0;
    check("both_nomove", bus.step_idx, 2);
    check("both_tgl", bus.pattern[8 +: 4], 4'b0001);

    // Program steps 0 and 1, then play
    pulse_right(); pulse_right();
    pulse_tgl(4'b0001);
    pulse_left();
    pulse_tgl(4'b0100);
    bus.step_period = PW'(10);
    bus.gate_len    = PW'(4);
    bus.mode        = 2'b01;
    for (int k = 1; k <= 80; k++) begin
      cycle();
      if (k <= 14) begin
        check("play_gate0", bus.gate[0], (k >= 1 && k <= 4));
        check("play_gate2", bus.gate[2], (k >= 11 && k <= 14));
        check("play_tick", bus.step_tick, (k == 10));
      end
    end
    check("play_wrap_idx", bus.step_idx, 0);
    check("play_wrap_tick", bus.step_tick, 1'b1);

    // Pause at step 5 counter 6, resume, then period 0
    for (int k = 0; k < 56; k++) cycle();
    check("pre_pause_idx", bus.step_idx, 5);
    bus.mode = 2'b11;
    for (int k = 0; k < 50; k++) begin
      cycle();
      check("pause_tick", bus.step_tick, 1'b0);
    end
    check("pause_idx", bus.step_idx, 5);
    bus.mode = 2'b01;
    for (int j = 1; j <= 4; j++) begin
      cycle();
      check("resume_tick", bus.step_tick, (j == 4));
    end
    check("resume_idx", bus.step_idx, 6);
    bus.step_period = '0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      check("p0_tick", bus.step_tick, 1'b1);
    end
    check("p0_idx", bus.step_idx, 1);

    // Mixer corner cases
    bus.mode = 2'b00;
    set_smpl(100, 100, 0, 0);       cycle(); check("mix_clamp_hi", bus.mix_out, 63);
    set_smpl(-128, -128, -128, -128); cycle(); check("mix_clamp_lo", bus.mix_out, 0);
    set_smpl(100, 100, -100, -100); cycle(); check("mix_zero", bus.mix_out, 32);
    bus.mute = 4'b0001;
    set_smpl(100, 100, 0, 0);       cycle(); check("mix_mute", bus.mix_out, 57);
    bus.mute = '0;

    // RAW mode
    bus.mode     = 2'b10;
    bus.raw_trig = 4'b0110;
    cycle();
    check("raw_gate", bus.gate, 4'b0110);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      bus.mode        = 2'($urandom_range(0, 3));
      bus.cur_left    = 1'($urandom_range(0, 1));
      bus.cur_right   = 1'($urandom_range(0, 1));
      bus.tgl         = N_CH'($urandom);
      bus.raw_trig    = N_CH'($urandom) & N_CH'($urandom);
      bus.mute        = N_CH'($urandom) & N_CH'($urandom);
      bus.step_period = PW'($urandom_range(0, 6));
      bus.gate_len    = PW'($urandom_range(0, 7));
      bus.smpl_in     = (N_CH*SW)'($urandom);
      cycle();
    end

    // Reset asserted mid-PLAY
    bus.cur_left = 1'b0; bus.cur_right = 1'b0; bus.tgl = '0;
    bus.raw_trig = '0; bus.mute = '0;
    bus.mode = 2'b00;
    pulse_tgl(4'b1111);
    bus.mode        = 2'b01;
    bus.step_period = PW'(10);
    bus.gate_len    = PW'(10);
    set_smpl(50, 20, 0, 0);
    for (int k = 0; k < 13; k++) cycle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_gate", bus.gate, 4'b0000);
    check("rst_pattern", bus.pattern, 0);
    check("rst_mix", bus.mix_out, 32);
    check("rst_idx", bus.step_idx, 0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/step_seq_mixer.md
Name: step_seq_mixer

Overview:
- Parametrised next-generation drum step sequencer core with an N-channel saturating mixer.
- Holds an N_STEPS x N_CH trigger pattern, edited through a cursor, and plays it back at a programmable step period with a programmable gate length.
- Mixes N_CH signed sample streams into one offset-binary word for the PWM audio stage.
- Sits between the keypad/mode controller and the sample players and PWM.

Parameters:
N_CH, 4, number of sample channels (2..8)
N_STEPS, 8, number of steps in the pattern (2..16)
PW, 20, width of step_period / gate_len counters
SW, 8, signed sample width
OUT_SHIFT, 2, right shift applied to offset-binary mix output

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
mode  in  2  00 EDIT, 01 PLAY, 10 RAW, 11 PAUSE
cur_left  in  1  single-cycle pulse, move cursor to higher step index
cur_right  in  1  single-cycle pulse, move cursor to lower step index
tgl  in  N_CH  single-cycle pulses, toggle pattern bit at cursor (EDIT only)
raw_trig  in  N_CH  live trigger levels
mute  in  N_CH  per-channel mix mute
step_period  in  PW  clocks per step
gate_len  in  PW  clocks per step the gate stays high
smpl_in  in  N_CH*SW  signed samples, channel c at [c*SW +: SW]
step_onehot  out  N_STEPS  current step (PLAY/PAUSE) or cursor (EDIT)
step_idx  out  clog2(N_STEPS)  binary of step_onehot
pattern  out  N_STEPS*N_CH  pattern memory, step s at [s*N_CH +: N_CH]
gate  out  N_CH  trigger enables to sample players
step_tick  out  1  one-cycle pulse on every step advance
mix_out  out  SW-OUT_SHIFT  offset-binary mixed sample

Behaviour:
- Reset (rst low, async):
  - pattern = 0.
  - Cursor and play step = 0; step_onehot = 1, step_idx = 0.
  - Step counter = 0.
  - gate = 0, step_tick = 0.
  - mix_out = offset-binary zero: 1 << (SW-1-OUT_SHIFT).
- EDIT (00):
  - One cur_left pulse sets cursor = cursor+1, wrapping N_STEPS-1 -> 0.
  - One cur_right pulse sets cursor = cursor-1, wrapping 0 -> N_STEPS-1.
  - cur_left and cur_right in the same cycle: no move.
  - Each tgl[c] pulse XORs pattern[cursor][c]. A toggle and a cursor move in the same cycle apply the toggle at the old cursor.
  - gate = 0. Step counter and play step are held at 0.
- PLAY (01):
  - Step counter counts 0..P-1, where P = max(step_period, 1).
  - When the counter equals P-1 it wraps to 0, the play step increments (wrapping at N_STEPS-1), and step_tick pulses for one cycle.
  - Entering PLAY from EDIT or RAW starts at step 0, counter 0.
  - Entering PLAY from PAUSE resumes at the held step and counter.
- Gate, registered with 1-cycle latency: gate[c] = (pattern[step][c] & (counter < gate_len)) | raw_trig[c].
  - gate_len = 0 disables pattern triggers.
  - gate_len >= P gives a continuous gate.
- RAW (10): gate = raw_trig, registered. Counter and step are held at 0.
- PAUSE (11): counter and step are frozen. gate = raw_trig. No step_tick.
- Cursor is retained across all modes; only EDIT changes it.
- step_onehot / step_idx show the cursor in EDIT, the play step otherwise.
- A change to step_period mid-step takes effect at the next compare. If the counter is already >= P-1, it wraps on the next cycle.
- Mixer:
  - Each unmuted channel is sign-extended to SW+clog2(N_CH) bits; muted channels contribute 0.
  - The full sum is clamped to [-2^(SW-1), 2^(SW-1)-1].
  - The MSB is inverted to give offset binary, then the result is shifted right by OUT_SHIFT.
  - The mixer is registered with 1-cycle latency and runs in all modes.
  - There is no pairwise intermediate saturation; only the final sum is clamped.
- Reset asserted mid-step clears all state immediately. The first step after release starts at counter 0.

Test Plan:
1. Reset, mode=EDIT, 3 cur_left pulses -> step_idx=3, step_onehot=8'b0000_1000. Then 4 cur_right pulses -> step_idx=7 (wrap).
2. EDIT, cursor=2, tgl=4'b1001 -> pattern[2]=4'b1001. Second pulse -> pattern[2]=0. cur_left+cur_right+tgl[0] in the same cycle -> cursor stays 2, pattern[2][0]=1.
3. pattern[0]=4'b0001, pattern[1]=4'b0100, step_period=10, gate_len=4, switch to PLAY:
   - gate[0] high for cycles 1..4 after entry.
   - step_tick at cycle 10.
   - gate[2] high for cycles 11..14.
   - step wraps to 0 after 8*10 cycles.
4. PLAY mid-step 5, counter 6 -> PAUSE for 50 cycles -> counter/step unchanged, no step_tick. Return to PLAY -> step_tick after 4 more cycles (P=10). step_period=0 -> step advances every cycle.
5. Mixer, SW=8, OUT_SHIFT=2, N_CH=4:
   - smpl = 100,100,0,0 -> clamp 127 -> mix_out=63.
   - smpl = -128,-128,-128,-128 -> mix_out=0.
   - smpl = 100,100,-100,-100 -> sum 0 -> mix_out=32.
   - mute[0]=1 with 100,100,0,0 -> mix_out=(100^0x80)>>2=57.
6. RAW mode, raw_trig=4'b0110 -> gate=4'b0110 one cycle later. Assert rst mid-PLAY -> gate=0 and pattern=0 asynchronously, mix_out=32.
